// File: rtl/result_pkg.sv
// Shared widths and types for the result producer/collector pair.
package result_pkg;

  localparam int RESULT_W = 8;
  localparam int DROP_W   = 8;

  typedef logic [RESULT_W-1:0] result_t;

endpackage : result_pkg

// File: rtl/result_ram.sv
// DEPTH x RESULT_W storage: one synchronous write port, one asynchronous read port.
module result_ram
  import result_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  result_t       i_wdata,
  input  logic [AW-1:0] i_raddr,
  output result_t       o_rdata
);

  result_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : result_ram

// File: rtl/result_collector.sv
// First-word-fall-through FIFO behind a producer that cannot be stalled,
// with running sum, occupancy and drop statistics.
module result_collector
  import result_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SUM_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  result_t                      in_result,
  input  logic                         in_valid,
  input  logic                         clr,
  output result_t                      out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [SUM_W-1:0]             sum,
  output logic                         overflow,
  output logic [DROP_W-1:0]            drops
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic [SUM_W-1:0]  r_sum;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drops;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_accept;
  logic w_drop;
  logic w_write;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a beat.
  assign w_accept = in_valid && (!w_full || w_pop);
  assign w_drop   = in_valid && w_full && !w_pop;
  assign w_write  = w_accept && !clr;

  result_ram #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_write),
    .i_waddr (r_wrPtr),
    .i_wdata (in_result),
    .i_raddr (r_rdPtr),
    .o_rdata (out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_sum      <= '0;
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end else if (clr) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_sum      <= '0;
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end else begin
      if (w_accept) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
        r_sum   <= r_sum + SUM_W'(in_result);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_accept) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drops != '1) begin
          r_drops <= r_drops + DROP_W'(1);
        end
      end
    end
  end

  assign out_valid = !w_empty;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign sum       = r_sum;
  assign overflow  = r_overflow;
  assign drops     = r_drops;

endmodule : result_collector
